// File: rtl/rr_sel_gen_pkg.sv
// ============================================================================
// rr_sel_pkg : shared defaults, FSM state type and rotate-priority search
// Revision   : 1.0
// ============================================================================
`default_nettype none

package rr_sel_pkg;

  localparam int N_DEF    = 4;
  localparam int SELW_DEF = 2;
  localparam int CNTW_DEF = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Returns the first set request at or after ptr, wrapping modulo N.
  // Falls back to ptr when nothing is requested; callers qualify with |req.
  function automatic logic [SELW_DEF-1:0] nxt_idx(
    input logic [SELW_DEF-1:0] ptr,
    input logic [N_DEF-1:0]    req
  );
    logic [SELW_DEF-1:0] cand;
    logic                found;
    nxt_idx = ptr;
    found   = 1'b0;
    for (int i = 0; i < N_DEF; i++) begin
      cand = ptr + SELW_DEF'(i);
      if (!found && req[cand]) begin
        nxt_idx = cand;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_sel_gen_if.sv
// ============================================================================
// rr_sel_gen_if : request / select / handshake bundle between the select
//                 generator (master) and the mux consumer (slave)
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface rr_sel_gen_if
  import rr_sel_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int SELW = SELW_DEF,
  parameter int CNTW = CNTW_DEF
);

  logic [N-1:0]    req;
  logic [SELW-1:0] sel;
  logic            out_valid;
  logic            out_ready;
  logic [N-1:0]    gnt_oh;
  logic [CNTW-1:0] xfer_cnt;

  modport master (
    input  req,
    input  out_ready,
    output sel,
    output out_valid,
    output gnt_oh,
    output xfer_cnt
  );

  modport slave (
    output req,
    output out_ready,
    input  sel,
    input  out_valid,
    input  gnt_oh,
    input  xfer_cnt
  );

endinterface

`default_nettype wire

// File: rtl/rr_sel_gen_pick.sv
// ============================================================================
// rr_pick  : combinational rotate-priority finder (first req at/after ptr)
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick
  import rr_sel_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int SELW = SELW_DEF
)(
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] idx,
  output logic            any
);

  assign any = |req;

  generate
    if (N == N_DEF && SELW == SELW_DEF) begin : g_pkg_fn
      assign idx = nxt_idx(ptr, req);
    end else begin : g_generic
      // N is a power of two, so SELW-bit addition wraps the search for free.
      logic [SELW-1:0] w_cand;
      logic            w_found;
      always_comb begin
        idx     = ptr;
        w_found = 1'b0;
        w_cand  = ptr;
        for (int i = 0; i < N; i++) begin
          w_cand = ptr + SELW'(i);
          if (!w_found && req[w_cand]) begin
            idx     = w_cand;
            w_found = 1'b1;
          end
        end
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/rr_sel_gen.sv
// ============================================================================
// rr_sel_gen : round-robin select generator for a 4:1 mux with valid/ready
//              handshake and transfer counter. RR_SEL_LOCK_EN adds a lock
//              input that holds the search pointer on accept.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module rr_sel_gen
  import rr_sel_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int SELW = SELW_DEF,
  parameter int CNTW = CNTW_DEF
)(
  input  logic         clk,
  input  logic         rst,
`ifdef RR_SEL_LOCK_EN
  input  logic         lock,
`endif
  rr_sel_gen_if.master bus
);

  state_t          r_state, w_state_nxt;
  logic [SELW-1:0] r_ptr, w_ptr_nxt;
  logic [SELW-1:0] r_sel, w_sel_nxt;
  logic            r_valid, w_valid_nxt;
  logic [CNTW-1:0] r_cnt, w_cnt_nxt;

  logic            w_accept;
  logic            w_hold;
  logic [SELW-1:0] w_search_ptr;
  logic [SELW-1:0] w_idx;
  logic            w_any;

  rr_pick #(
    .N    (N),
    .SELW (SELW)
  ) u_pick (
    .req (bus.req),
    .ptr (w_search_ptr),
    .idx (w_idx),
    .any (w_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_valid <= w_valid_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // On accept the search starts from the post-accept pointer so a waiting
  // requester is re-picked in the same cycle with no bubble.
  always_comb begin
    w_accept     = r_valid & bus.out_ready;
    w_ptr_nxt    = r_ptr;
    w_search_ptr = r_ptr;
    w_hold       = 1'b0;
    if (w_accept) begin
`ifdef RR_SEL_LOCK_EN
      if (lock) begin
        w_hold = bus.req[r_sel];
      end else begin
        w_ptr_nxt    = r_sel + 1'b1;
        w_search_ptr = r_sel + 1'b1;
      end
`else
      w_ptr_nxt    = r_sel + 1'b1;
      w_search_ptr = r_sel + 1'b1;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_valid_nxt = r_valid;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_sel_nxt   = w_idx;
          w_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        // A pending grant is never retracted, even if its request drops.
        if (w_accept) begin
          w_cnt_nxt = r_cnt + 1'b1;
          if (w_any) begin
            w_sel_nxt = w_hold ? r_sel : w_idx;
          end else begin
            w_state_nxt = IDLE;
            w_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.sel       = r_sel;
  assign bus.out_valid = r_valid;
  assign bus.xfer_cnt  = r_cnt;
  assign bus.gnt_oh    = r_valid ? (N'(1) << r_sel) : '0;

endmodule

`default_nettype wire
